// File: rtl/iir_biquad_mc_pkg.sv
// Shared types and constants for the multi-channel biquad filter.
//   coef_addr_e  : coefficient bank address map (b0, b1, b2, a1, a2)
//   state_e      : sequencer states
//   acc_w()      : accumulator width for a given sample/coefficient width
//   default_coef : reset value of each tap (unity b0, zero elsewhere = identity)
package iir_pkg;

    typedef enum logic [2:0] {
        B0 = 3'd0,
        B1 = 3'd1,
        B2 = 3'd2,
        A1 = 3'd3,
        A2 = 3'd4
    } coef_addr_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        RND  = 2'd2,
        OUT  = 2'd3
    } state_e;

    localparam int NUM_TAPS = 5;
    localparam int LAST_TAP = NUM_TAPS - 1;

    // Three guard bits cover the sum of five full-scale products.
    function automatic int acc_w(input int dw, input int cw);
        return dw + cw + 3;
    endfunction

    function automatic int default_coef(input int tap, input int frac);
        return (tap == int'(B0)) ? (1 << frac) : 0;
    endfunction

endpackage

// File: rtl/iir_biquad_mc_if.sv
// Sample stream interface of the biquad filter.
//   in_valid/in_ready/in_ch/in_data : input sample handshake
//   out_valid/out_ch/out_data       : one-cycle result strobe with channel tag
// master = sample producer/result consumer, slave = the filter.
interface iir_biquad_mc_if #(
    parameter int DW  = 32,
    parameter int CHW = 2
);
    logic           in_valid;
    logic           in_ready;
    logic [CHW-1:0] in_ch;
    logic [DW-1:0]  in_data;
    logic           out_valid;
    logic [CHW-1:0] out_ch;
    logic [DW-1:0]  out_data;

    modport master (
        output in_valid, in_ch, in_data,
        input  in_ready, out_valid, out_ch, out_data
    );

    modport slave (
        input  in_valid, in_ch, in_data,
        output in_ready, out_valid, out_ch, out_data
    );
endinterface

// File: rtl/iir_biquad_mc_coef_bank.sv
// Coefficient bank for the biquad filter.
// Holds a shadow set written by the control bus and a working set used by
// the MAC; the working set is refreshed from the shadow only when a sample
// is accepted, so bus writes never disturb a computation in flight.
// Ports:
//   clk, reset_l       : clock, async active-low reset
//   coef_we/addr/data  : control bus write (addresses 5..7 ignored)
//   load               : sample accepted -> copy shadow into working set
//   tap_idx            : MAC step index 0..4
//   tap_coef           : working coefficient for that step
module iir_coef_bank
    import iir_pkg::*;
#(
    parameter int CW   = 18,
    parameter int FRAC = 16
) (
    input  logic          clk,
    input  logic          reset_l,
    input  logic          coef_we,
    input  logic [2:0]    coef_addr,
    input  logic [CW-1:0] coef_data,
    input  logic          load,
    input  logic [2:0]    tap_idx,
    output logic [CW-1:0] tap_coef
);

    logic [CW-1:0] shadow_q [NUM_TAPS];
    logic [CW-1:0] shadow_d [NUM_TAPS];
    logic [CW-1:0] work_q   [NUM_TAPS];
    logic [CW-1:0] work_d   [NUM_TAPS];

    // The copy takes the pre-edge shadow, so a write coinciding with an
    // accept lands in the shadow and only reaches the following sample.
    always_comb begin
        shadow_d = shadow_q;
        work_d   = work_q;
        for (int i = 0; i < NUM_TAPS; i++) begin
            if (coef_we && (coef_addr == 3'(i))) begin
                shadow_d[i] = coef_data;
            end
        end
        if (load) begin
            work_d = shadow_q;
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                shadow_q[i] <= CW'(default_coef(i, FRAC));
                work_q[i]   <= CW'(default_coef(i, FRAC));
            end
        end else begin
            shadow_q <= shadow_d;
            work_q   <= work_d;
        end
    end

    always_comb begin
        tap_coef = '0;
        for (int i = 0; i < NUM_TAPS; i++) begin
            if (tap_idx == 3'(i)) begin
                tap_coef = work_q[i];
            end
        end
    end

endmodule

// File: rtl/iir_biquad_mc.sv
// Multi-channel fixed-point direct-form-I biquad IIR filter.
//   y = b0*x0 + b1*x1 + b2*x2 - a1*y1 - a2*y2, one shared multiplier,
//   five MAC cycles, one round/saturate cycle, one output cycle.
// Ports:
//   clk, reset_l        : clock, async active-low reset
//   coef_we/addr/data   : coefficient bus (0=b0 1=b1 2=b2 3=a1 4=a2)
//   bypass              : output the input sample, latency unchanged
//   clr_state           : sync clear of history, armed flags, sat_flag;
//                         aborts any computation in flight
//   s_if (slave)        : sample in/out stream with channel tag
//   sat_flag            : sticky saturation indicator
module iir_biquad_mc
    import iir_pkg::*;
#(
    parameter int DW   = 32,
    parameter int CW   = 18,
    parameter int FRAC = 16,
    parameter int NCH  = 4,
    parameter int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic          clk,
    input  logic          reset_l,
    input  logic          coef_we,
    input  logic [2:0]    coef_addr,
    input  logic [CW-1:0] coef_data,
    input  logic          bypass,
    input  logic          clr_state,
    iir_biquad_mc_if.slave s_if,
    output logic          sat_flag
);

    localparam int ACC_W = acc_w(DW, CW);
    localparam logic signed [ACC_W-1:0] ROUND_HALF = ACC_W'(1) << (FRAC - 1);
    localparam logic [DW-1:0] Y_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] Y_MIN = {1'b1, {(DW-1){1'b0}}};

    state_e                   state_q, state_d;
    logic [2:0]               mac_idx_q, mac_idx_d;
    logic [CHW-1:0]           ch_q, ch_d;
    logic [DW-1:0]            x0_q, x0_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     gate_q, gate_d;
    logic [DW-1:0]            y_sat_q, y_sat_d;
    logic [DW-1:0]            out_data_q, out_data_d;
    logic [CHW-1:0]           out_ch_q, out_ch_d;
    logic                     sat_q, sat_d;
    logic                     ready_en_q, ready_en_d;
    logic [NCH-1:0]           armed_q, armed_d;

    logic [DW-1:0] x1_q [NCH];
    logic [DW-1:0] x1_d [NCH];
    logic [DW-1:0] x2_q [NCH];
    logic [DW-1:0] x2_d [NCH];
    logic [DW-1:0] y1_q [NCH];
    logic [DW-1:0] y1_d [NCH];
    logic [DW-1:0] y2_q [NCH];
    logic [DW-1:0] y2_d [NCH];

    logic                     in_ready_w;
    logic                     accept;
    logic [CHW-1:0]           in_ch_norm;
    logic [CW-1:0]            tap_coef;
    logic [DW-1:0]            operand;
    logic signed [ACC_W-1:0]  coef_ext;
    logic signed [ACC_W-1:0]  opnd_ext;
    logic signed [ACC_W-1:0]  product;
    logic signed [ACC_W-1:0]  rnd_sum;
    logic signed [ACC_W-1:0]  shifted;
    logic                     pos_ovf;
    logic                     neg_ovf;
    logic [DW-1:0]            y_sat_w;

    // ready_en_q keeps in_ready low until the first edge after reset release.
    assign in_ready_w = ready_en_q && (state_q == IDLE) && !clr_state;
    assign accept     = s_if.in_valid && in_ready_w;
    assign in_ch_norm = (int'(s_if.in_ch) < NCH) ? s_if.in_ch : '0;

    assign s_if.in_ready  = in_ready_w;
    assign s_if.out_valid = (state_q == OUT) && !clr_state;
    assign s_if.out_ch    = out_ch_q;
    assign s_if.out_data  = out_data_q;
    assign sat_flag       = sat_q;

    iir_coef_bank #(
        .CW   (CW),
        .FRAC (FRAC)
    ) u_coef_bank (
        .clk       (clk),
        .reset_l   (reset_l),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .load      (accept),
        .tap_idx   (mac_idx_q),
        .tap_coef  (tap_coef)
    );

    // Operand select follows the tap order b0*x0, b1*x1, b2*x2, a1*y1, a2*y2.
    // Both factors are sign-extended to the accumulator width; the true
    // product always fits, so the truncated multiply is exact.
    always_comb begin
        operand = '0;
        case (mac_idx_q)
            3'd0:    operand = x0_q;
            3'd1:    operand = x1_q[ch_q];
            3'd2:    operand = x2_q[ch_q];
            3'd3:    operand = y1_q[ch_q];
            3'd4:    operand = y2_q[ch_q];
            default: operand = '0;
        endcase
        coef_ext = ACC_W'(signed'(tap_coef));
        opnd_ext = ACC_W'(signed'(operand));
        product  = coef_ext * opnd_ext;
    end

    // Round half up, then saturate: overflow whenever the bits above the
    // output sign bit are not a copy of the accumulator sign.
    always_comb begin
        rnd_sum = acc_q + ROUND_HALF;
        shifted = rnd_sum >>> FRAC;
        pos_ovf = !shifted[ACC_W-1] && (|shifted[ACC_W-2:DW-1]);
        neg_ovf = shifted[ACC_W-1] && !(&shifted[ACC_W-2:DW-1]);
        if (pos_ovf) begin
            y_sat_w = Y_MAX;
        end else if (neg_ovf) begin
            y_sat_w = Y_MIN;
        end else begin
            y_sat_w = shifted[DW-1:0];
        end
    end

    // clr_state overrides every state: history and armed flags are wiped,
    // sat_flag drops and any computation in flight is abandoned.
    // Warm-up gating (gate_q) blanks the output and freezes history for a
    // zero sample on a channel that has not yet seen a nonzero one.
    always_comb begin
        state_d    = state_q;
        mac_idx_d  = mac_idx_q;
        ch_d       = ch_q;
        x0_d       = x0_q;
        acc_d      = acc_q;
        gate_d     = gate_q;
        y_sat_d    = y_sat_q;
        out_data_d = out_data_q;
        out_ch_d   = out_ch_q;
        sat_d      = sat_q;
        ready_en_d = 1'b1;
        armed_d    = armed_q;
        x1_d       = x1_q;
        x2_d       = x2_q;
        y1_d       = y1_q;
        y2_d       = y2_q;

        if (clr_state) begin
            state_d   = IDLE;
            mac_idx_d = '0;
            sat_d     = 1'b0;
            armed_d   = '0;
            for (int i = 0; i < NCH; i++) begin
                x1_d[i] = '0;
                x2_d[i] = '0;
                y1_d[i] = '0;
                y2_d[i] = '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d   = MAC;
                        mac_idx_d = '0;
                        ch_d      = in_ch_norm;
                        x0_d      = s_if.in_data;
                        acc_d     = '0;
                        gate_d    = !armed_q[in_ch_norm] && (s_if.in_data == '0);
                    end
                end
                MAC: begin
                    if (mac_idx_q >= 3'(A1)) begin
                        acc_d = acc_q - product;
                    end else begin
                        acc_d = acc_q + product;
                    end
                    if (mac_idx_q == 3'(LAST_TAP)) begin
                        state_d   = RND;
                        mac_idx_d = '0;
                    end else begin
                        mac_idx_d = mac_idx_q + 3'd1;
                    end
                end
                RND: begin
                    y_sat_d  = y_sat_w;
                    out_ch_d = ch_q;
                    if (gate_q) begin
                        out_data_d = '0;
                    end else if (bypass) begin
                        out_data_d = x0_q;
                    end else begin
                        out_data_d = y_sat_w;
                    end
                    if (pos_ovf || neg_ovf) begin
                        sat_d = 1'b1;
                    end
                    state_d = OUT;
                end
                OUT: begin
                    if (!gate_q) begin
                        x2_d[ch_q]    = x1_q[ch_q];
                        x1_d[ch_q]    = x0_q;
                        y2_d[ch_q]    = y1_q[ch_q];
                        y1_d[ch_q]    = y_sat_q;
                        armed_d[ch_q] = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q    <= IDLE;
            mac_idx_q  <= '0;
            ch_q       <= '0;
            x0_q       <= '0;
            acc_q      <= '0;
            gate_q     <= 1'b0;
            y_sat_q    <= '0;
            out_data_q <= '0;
            out_ch_q   <= '0;
            sat_q      <= 1'b0;
            ready_en_q <= 1'b0;
            armed_q    <= '0;
            for (int i = 0; i < NCH; i++) begin
                x1_q[i] <= '0;
                x2_q[i] <= '0;
                y1_q[i] <= '0;
                y2_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            mac_idx_q  <= mac_idx_d;
            ch_q       <= ch_d;
            x0_q       <= x0_d;
            acc_q      <= acc_d;
            gate_q     <= gate_d;
            y_sat_q    <= y_sat_d;
            out_data_q <= out_data_d;
            out_ch_q   <= out_ch_d;
            sat_q      <= sat_d;
            ready_en_q <= ready_en_d;
            armed_q    <= armed_d;
            x1_q       <= x1_d;
            x2_q       <= x2_d;
            y1_q       <= y1_d;
            y2_q       <= y2_d;
        end
    end

endmodule

// File: tb/tb_iir_biquad_mc.sv
// Directed testbench for iir_biquad_mc: identity, averaging, rounding,
// channel isolation, bypass, saturation, warm-up, mid-computation
// coefficient write, clr_state abort and reset mid-operation.
module tb_iir_biquad_mc;

    logic        clk = 1'b0;
    logic        reset_l = 1'b1;
    logic        coef_we;
    logic [2:0]  coef_addr;
    logic [17:0] coef_data;
    logic        bypass;
    logic        clr_state;
    logic        sat_flag;

    int checks = 0;
    int failures = 0;

    iir_biquad_mc_if #(.DW(32), .CHW(2)) sif ();

    iir_biquad_mc #(
        .DW   (32),
        .CW   (18),
        .FRAC (16),
        .NCH  (4),
        .CHW  (2)
    ) dut (
        .clk       (clk),
        .reset_l   (reset_l),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .bypass    (bypass),
        .clr_state (clr_state),
        .s_if      (sif),
        .sat_flag  (sat_flag)
    );

    // 100 MHz clock; inputs change and outputs are sampled 1 ns after the rising edge.
    always #5 clk = ~clk;

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Waits (bounded) for in_ready, then presents one sample for one cycle.
    // Returns 1 ns into cycle 1 (the first MAC cycle).
    task automatic applyStimulus(input logic [1:0] ch, input logic [31:0] data);
        int waited = 0;
        while (sif.in_ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        if (sif.in_ready !== 1'b1) begin
            checkOutput("ready_wait", 64'(sif.in_ready), 64'd1);
        end
        sif.in_valid = 1'b1;
        sif.in_ch    = ch;
        sif.in_data  = data;
        tick();
        sif.in_valid = 1'b0;
    endtask

    // Waits (bounded) for out_valid starting from cycle start_lat and checks
    // latency, channel and data; ends 1 ns into the cycle after the strobe.
    task automatic awaitResult(input string tag, input int start_lat, input logic [1:0] exp_ch,
                               input logic [31:0] exp_data);
        int lat = start_lat;
        while (sif.out_valid !== 1'b1 && lat < 12) begin
            tick();
            lat++;
        end
        checkOutput({tag, "_latency"}, 64'(lat), 64'd7);
        checkOutput({tag, "_ch"}, 64'(sif.out_ch), 64'(exp_ch));
        checkOutput({tag, "_data"}, 64'(sif.out_data), 64'(exp_data));
        tick();
    endtask

    task automatic runSample(input string tag, input logic [1:0] ch, input logic [31:0] data,
                             input logic [31:0] exp_data);
        applyStimulus(ch, data);
        awaitResult(tag, 1, ch, exp_data);
    endtask

    task automatic writeCoef(input logic [2:0] addr, input logic [17:0] data);
        coef_we   = 1'b1;
        coef_addr = addr;
        coef_data = data;
        tick();
        coef_we   = 1'b0;
    endtask

    task automatic pulseClr();
        clr_state = 1'b1;
        tick();
        clr_state = 1'b0;
    endtask

    // Linear sequence of directed steps with hand-computed expectations.
    initial begin
        logic ready_seen;
        logic valid_seen;
        int   valid_at;

        sif.in_valid = 1'b0;
        sif.in_ch    = '0;
        sif.in_data  = '0;
        coef_we      = 1'b0;
        coef_addr    = '0;
        coef_data    = '0;
        bypass       = 1'b0;
        clr_state    = 1'b0;

        #1 reset_l = 1'b0;
        tick();
        tick();
        checkOutput("rst_in_ready", 64'(sif.in_ready), 64'd0);
        checkOutput("rst_out_valid", 64'(sif.out_valid), 64'd0);
        checkOutput("rst_out_data", 64'(sif.out_data), 64'd0);
        checkOutput("rst_out_ch", 64'(sif.out_ch), 64'd0);
        checkOutput("rst_sat_flag", 64'(sat_flag), 64'd0);
        reset_l = 1'b1;
        #1;
        checkOutput("release_ready_low", 64'(sif.in_ready), 64'd0);
        tick();
        checkOutput("release_ready_high", 64'(sif.in_ready), 64'd1);

        $display("[TB] identity filter after reset");
        applyStimulus(2'd0, 32'd1000);
        ready_seen = 1'b0;
        valid_at   = 0;
        for (int c = 1; c <= 7; c++) begin
            if (sif.in_ready !== 1'b0) ready_seen = 1'b1;
            if (sif.out_valid === 1'b1 && valid_at == 0) valid_at = c;
            if (c < 7) tick();
        end
        checkOutput("id_ready_busy", 64'(ready_seen), 64'd0);
        checkOutput("id_valid_cycle", 64'(valid_at), 64'd7);
        checkOutput("id_out_ch", 64'(sif.out_ch), 64'd0);
        checkOutput("id_out_data", 64'(sif.out_data), 64'd1000);
        tick();
        checkOutput("id_valid_one_cycle", 64'(sif.out_valid), 64'd0);
        checkOutput("id_ready_cycle8", 64'(sif.in_ready), 64'd1);

        $display("[TB] averaging b0=b1=0.5");
        writeCoef(3'd0, 18'd32768);
        writeCoef(3'd1, 18'd32768);
        runSample("avg1", 2'd1, 32'd1000, 32'd500);
        runSample("avg2", 2'd1, 32'd2000, 32'd1500);

        pulseClr();
        runSample("round", 2'd3, 32'd3, 32'd2);

        $display("[TB] channel isolation");
        pulseClr();
        runSample("iso_ch0_a", 2'd0, 32'd100, 32'd50);
        runSample("iso_ch1_a", 2'd1, 32'd200, 32'd100);
        runSample("iso_ch0_b", 2'd0, 32'd300, 32'd200);
        runSample("iso_ch1_b", 2'd1, 32'd400, 32'd300);

        $display("[TB] bypass keeps history running");
        bypass = 1'b1;
        runSample("bypass", 2'd1, 32'd777, 32'd777);
        bypass = 1'b0;
        runSample("post_bypass", 2'd1, 32'd1000, 32'd889);

        $display("[TB] saturation");
        pulseClr();
        writeCoef(3'd0, 18'd131071);
        writeCoef(3'd1, 18'd0);
        runSample("sat_pos", 2'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        checkOutput("sat_flag_set", 64'(sat_flag), 64'd1);
        runSample("sat_hold", 2'd0, 32'd10, 32'd20);
        checkOutput("sat_flag_sticky", 64'(sat_flag), 64'd1);
        pulseClr();
        checkOutput("sat_flag_cleared", 64'(sat_flag), 64'd0);
        runSample("sat_neg", 2'd1, 32'h8000_0000, 32'h8000_0000);
        checkOutput("sat_flag_neg", 64'(sat_flag), 64'd1);
        pulseClr();
        checkOutput("sat_flag_cleared2", 64'(sat_flag), 64'd0);

        $display("[TB] warm-up gate and mid-computation write");
        writeCoef(3'd0, 18'd65536);
        runSample("warm_zero_a", 2'd2, 32'd0, 32'd0);
        runSample("warm_zero_b", 2'd2, 32'd0, 32'd0);
        runSample("warm_first", 2'd2, 32'd5, 32'd5);
        applyStimulus(2'd2, 32'd7);
        writeCoef(3'd0, 18'd0);
        awaitResult("mid_write", 2, 2'd2, 32'd7);
        runSample("after_write", 2'd2, 32'd9, 32'd0);

        $display("[TB] clr_state abort in MAC");
        writeCoef(3'd0, 18'd32768);
        writeCoef(3'd1, 18'd32768);
        pulseClr();
        runSample("abort_pre", 2'd3, 32'd1000, 32'd500);
        applyStimulus(2'd3, 32'd1000);
        tick();
        tick();
        clr_state = 1'b1;
        #1;
        valid_seen = (sif.out_valid !== 1'b0);
        tick();
        clr_state = 1'b0;
        #1;
        if (sif.out_valid !== 1'b0) valid_seen = 1'b1;
        tick();
        checkOutput("abort_ready", 64'(sif.in_ready), 64'd1);
        for (int c = 0; c < 6; c++) begin
            if (sif.out_valid !== 1'b0) valid_seen = 1'b1;
            tick();
        end
        checkOutput("abort_no_valid", 64'(valid_seen), 64'd0);
        runSample("abort_post", 2'd3, 32'd1000, 32'd500);

        $display("[TB] reset mid-computation");
        applyStimulus(2'd1, 32'd1234);
        tick();
        reset_l = 1'b0;
        #1;
        checkOutput("midrst_in_ready", 64'(sif.in_ready), 64'd0);
        checkOutput("midrst_out_valid", 64'(sif.out_valid), 64'd0);
        checkOutput("midrst_out_ch", 64'(sif.out_ch), 64'd0);
        checkOutput("midrst_out_data", 64'(sif.out_data), 64'd0);
        checkOutput("midrst_sat_flag", 64'(sat_flag), 64'd0);
        tick();
        tick();
        reset_l = 1'b1;
        tick();
        checkOutput("midrst_ready_back", 64'(sif.in_ready), 64'd1);
        runSample("post_rst_identity", 2'd1, 32'd1234, 32'd1234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
